// File: rtl/freq_peak_est.sv
// rtl/freq_peak_est.sv - segment peak tracker and upward threshold-crossing counter
// Two independent valid-framed engines sharing one sample input.
module freq_peak_est #(
  parameter int W  = 16,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [W-1:0]  x,
  input  logic          peak_find_v,
  input  logic          freq_est_v,
  input  logic [W-1:0]  threshold,
  output logic [W-1:0]  peak,
  output logic          peak_find_vout,
  output logic [CW-1:0] count,
  output logic          freq_est_vout
);

  logic [W-1:0]  r_peak;
  logic          r_pf_v_d;
  logic          r_pf_vout;
  logic [CW-1:0] r_count;
  logic [W-1:0]  r_x_prev;
  logic          r_prev_ok;
  logic          r_fe_v_d;
  logic          r_fe_vout;

  logic w_pf_start;
  logic w_fe_start;
  logic w_pf_greater;
  logic w_cross;
  logic w_cnt_max;

  // A segment starts on any valid cycle whose predecessor was not valid (history is cleared by reset).
  assign w_pf_start   = peak_find_v & ~r_pf_v_d;
  assign w_fe_start   = freq_est_v & ~r_fe_v_d;
  assign w_pf_greater = $signed(x) > $signed(r_peak);
  assign w_cross      = r_prev_ok & ($signed(r_x_prev) < $signed(threshold))
                                  & ($signed(x) >= $signed(threshold));
  assign w_cnt_max    = &r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_peak    <= '0;
      r_pf_v_d  <= 1'b0;
      r_pf_vout <= 1'b0;
      r_count   <= '0;
      r_x_prev  <= '0;
      r_prev_ok <= 1'b0;
      r_fe_v_d  <= 1'b0;
      r_fe_vout <= 1'b0;
    end else begin
      r_pf_v_d  <= peak_find_v;
      r_pf_vout <= r_pf_v_d & ~peak_find_v;
      if (w_pf_start) begin
        r_peak <= x;
      end else if (peak_find_v && w_pf_greater) begin
        r_peak <= x;
      end

      r_fe_v_d  <= freq_est_v;
      r_fe_vout <= r_fe_v_d & ~freq_est_v;
      if (w_fe_start) begin
        r_count   <= '0;
        r_x_prev  <= x;
        r_prev_ok <= 1'b1;
      end else if (freq_est_v) begin
        r_x_prev <= x;
        if (w_cross && !w_cnt_max) begin
          r_count <= r_count + 1'b1;
        end
      end else begin
        r_prev_ok <= 1'b0;
      end
    end
  end

  assign peak           = r_peak;
  assign peak_find_vout = r_pf_vout;
  assign count          = r_count;
  assign freq_est_vout  = r_fe_vout;

endmodule

// File: tb/tb_freq_peak_est.sv
// tb/tb_freq_peak_est.sv - directed self-checking bench for freq_peak_est
// Inputs change 1 ns after a rising edge; outputs are read at that same point.
module tb_freq_peak_est;
  localparam int W  = 16;
  localparam int CW = 4;

  logic          clk;
  logic          rst;
  logic [W-1:0]  x;
  logic          peak_find_v;
  logic          freq_est_v;
  logic [W-1:0]  threshold;
  logic [W-1:0]  peak;
  logic          peak_find_vout;
  logic [CW-1:0] count;
  logic          freq_est_vout;

  int checks;
  int failures;

  freq_peak_est #(.W(W), .CW(CW)) dut (
    .clk            (clk),
    .rst            (rst),
    .x              (x),
    .peak_find_v    (peak_find_v),
    .freq_est_v     (freq_est_v),
    .threshold      (threshold),
    .peak           (peak),
    .peak_find_vout (peak_find_vout),
    .count          (count),
    .freq_est_vout  (freq_est_vout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; x = 16'sd100; peak_find_v = 1'b1; freq_est_v = 1'b1; threshold = 16'sd5;
    tick();
    checks++;
    if (peak !== 16'd0 || count !== 4'd0 || peak_find_vout !== 1'b0 || freq_est_vout !== 1'b0) begin
      failures++;
      $display("FAIL reset: peak=%0d count=%0d pvout=%b fvout=%b, want 0 0 0 0",
               peak, count, peak_find_vout, freq_est_vout);
    end
    rst = 1'b0; peak_find_v = 1'b0; freq_est_v = 1'b0;
    tick();
  endtask

  task automatic test_peak_segment();
    logic signed [W-1:0] xs [6] = '{16'sd3, -16'sd7, 16'sd12, 16'sd5, -16'sd20, 16'sd9};
    logic signed [W-1:0] ps [6] = '{16'sd3, 16'sd3, 16'sd12, 16'sd12, 16'sd12, 16'sd12};
    int pulses = 0;
    for (int i = 0; i < 6; i++) begin
      x = xs[i]; peak_find_v = 1'b1;
      tick();
      if (peak_find_vout) pulses++;
      checks++;
      if (peak !== ps[i]) begin
        failures++;
        $display("FAIL peak_seq[%0d]: got %0d want %0d", i, $signed(peak), ps[i]);
      end
    end
    peak_find_v = 1'b0; x = 16'sd50;
    tick();
    checks++;
    if (peak_find_vout !== 1'b1) begin
      failures++;
      $display("FAIL peak_vout: got %b want 1", peak_find_vout);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      if (peak_find_vout) pulses++;
    end
    checks++;
    if (pulses != 0 || peak !== 16'sd12) begin
      failures++;
      $display("FAIL peak_hold: extra_pulses=%0d peak=%0d want 0 and 12", pulses, $signed(peak));
    end
  endtask

  task automatic test_negative_and_restart();
    logic signed [W-1:0] xs [3] = '{-16'sd5, -16'sd2, -16'sd9};
    for (int i = 0; i < 3; i++) begin
      x = xs[i]; peak_find_v = 1'b1;
      tick();
    end
    peak_find_v = 1'b0;
    tick();
    checks++;
    if (peak !== -16'sd2 || peak_find_vout !== 1'b1) begin
      failures++;
      $display("FAIL neg_peak: peak=%0d vout=%b want -2 and 1", $signed(peak), peak_find_vout);
    end
    x = 16'sd1; peak_find_v = 1'b1;
    tick();
    checks++;
    if (peak !== 16'sd1 || peak_find_vout !== 1'b0) begin
      failures++;
      $display("FAIL neg_restart: peak=%0d vout=%b want 1 and 0", $signed(peak), peak_find_vout);
    end
    peak_find_v = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_crossings();
    logic signed [W-1:0] xs [8] = '{16'sd0, 16'sd4, 16'sd5, 16'sd1, 16'sd3, -16'sd2, 16'sd8, 16'sd2};
    logic [CW-1:0]       cs [8] = '{4'd0, 4'd1, 4'd1, 4'd1, 4'd2, 4'd2, 4'd3, 4'd3};
    int pulses = 0;
    threshold = 16'sd3;
    for (int i = 0; i < 8; i++) begin
      x = xs[i]; freq_est_v = 1'b1;
      tick();
      if (freq_est_vout) pulses++;
      checks++;
      if (count !== cs[i]) begin
        failures++;
        $display("FAIL cross_seq[%0d]: got %0d want %0d", i, count, cs[i]);
      end
    end
    freq_est_v = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (freq_est_vout) pulses++;
    end
    checks++;
    if (count !== 4'd3 || pulses != 1) begin
      failures++;
      $display("FAIL cross_final: count=%0d pulses=%0d want 3 and 1", count, pulses);
    end
  endtask

  task automatic test_back_to_back();
    logic signed [W-1:0] s1 [3] = '{16'sd5, -16'sd1, 16'sd2};
    threshold = 16'sd0;
    for (int i = 0; i < 3; i++) begin
      x = s1[i]; freq_est_v = 1'b1;
      tick();
      if (i == 0) begin
        checks++;
        if (count !== 4'd0) begin
          failures++;
          $display("FAIL b2b_first: got %0d want 0", count);
        end
      end
    end
    freq_est_v = 1'b0; x = -16'sd10;
    tick();
    checks++;
    if (count !== 4'd1 || freq_est_vout !== 1'b1) begin
      failures++;
      $display("FAIL b2b_seg1: count=%0d vout=%b want 1 and 1", count, freq_est_vout);
    end
    x = -16'sd3; freq_est_v = 1'b1;
    tick();
    checks++;
    if (count !== 4'd0 || freq_est_vout !== 1'b0) begin
      failures++;
      $display("FAIL b2b_restart: count=%0d vout=%b want 0 and 0", count, freq_est_vout);
    end
    x = 16'sd4;
    tick();
    freq_est_v = 1'b0;
    tick();
    checks++;
    if (count !== 4'd1 || freq_est_vout !== 1'b1) begin
      failures++;
      $display("FAIL b2b_seg2: count=%0d vout=%b want 1 and 1", count, freq_est_vout);
    end
    tick();
  endtask

  task automatic test_saturation();
    threshold = 16'sd0;
    for (int i = 0; i < 40; i++) begin
      x = (i % 2 == 0) ? -16'sd1 : 16'sd1; freq_est_v = 1'b1;
      tick();
    end
    freq_est_v = 1'b0;
    tick();
    checks++;
    if (count !== 4'd15) begin
      failures++;
      $display("FAIL saturate: got %0d want 15", count);
    end
    tick();
  endtask

  task automatic test_sine_flow();
    logic signed [W-1:0] s [200];
    logic signed [W-1:0] pk_exp;
    int pulses = 0;
    real v;
    for (int n = 0; n < 200; n++) begin
      v = 8000.0 * $sin(2.0 * 3.14159265358979 * n / 40.0);
      s[n] = 16'($rtoi(v >= 0.0 ? v + 0.5 : v - 0.5));
    end
    for (int n = 0; n < 200; n++) begin
      x = s[n]; peak_find_v = 1'b1;
      tick();
    end
    peak_find_v = 1'b0;
    tick();
    pk_exp = 16'sd8000;
    checks++;
    if (peak !== pk_exp || peak_find_vout !== 1'b1) begin
      failures++;
      $display("FAIL sine_peak: peak=%0d vout=%b want 8000 and 1", $signed(peak), peak_find_vout);
    end
    threshold = pk_exp >>> 2;
    for (int n = 0; n < 200; n++) begin
      x = s[n]; freq_est_v = 1'b1;
      tick();
      if (freq_est_vout) pulses++;
    end
    freq_est_v = 1'b0;
    tick();
    if (freq_est_vout) pulses++;
    checks++;
    if (count < 4'd4 || count > 4'd6 || pulses != 1) begin
      failures++;
      $display("FAIL sine_count: count=%0d pulses=%0d want 5 (+-1) and 1", count, pulses);
    end
    tick();
  endtask

  task automatic test_abort();
    int pulses = 0;
    threshold = 16'sd0;
    for (int i = 0; i < 6; i++) begin
      x = (i % 2 == 0) ? -16'sd1 : 16'sd1; freq_est_v = 1'b1;
      tick();
    end
    checks++;
    if (count !== 4'd3) begin
      failures++;
      $display("FAIL abort_pre: got %0d want 3", count);
    end
    rst = 1'b1;
    tick();
    checks++;
    if (count !== 4'd0) begin
      failures++;
      $display("FAIL abort_reset: got %0d want 0", count);
    end
    rst = 1'b0; freq_est_v = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (freq_est_vout) pulses++;
    end
    checks++;
    if (pulses != 0 || count !== 4'd0) begin
      failures++;
      $display("FAIL abort_vout: pulses=%0d count=%0d want 0 and 0", pulses, count);
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b0; x = '0; peak_find_v = 1'b0; freq_est_v = 1'b0; threshold = '0;
    #1;
    test_reset();
    test_peak_segment();
    test_negative_and_restart();
    test_crossings();
    test_back_to_back();
    test_saturation();
    test_sine_flow();
    test_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
